// File: rtl/air_hockey_pkg.sv
// Shared air-hockey definitions: screen/paddle geometry, puck timing, colours
// and the puck state encoding, common to the paddle and puck stages.
package air_hockey_pkg;

  localparam int WIDTH       = 96;
  localparam int HEIGHT      = 64;
  localparam int PADDLE_H    = 20;
  localparam int PADDLE_W    = 3;
  localparam int BORDER      = 3;

  localparam int PUCK_HALF   = 1;
  localparam int SPEED       = 1;
  localparam int SERVE_TICKS = 8;
  localparam int GOAL_TICKS  = 16;
  localparam int WIN_SCORE   = 7;

  localparam logic [15:0] COL_WHITE = 16'hFFFF;
  localparam logic [15:0] COL_BLACK = 16'h0000;

  localparam logic [6:0] CENTRE_X = 7'(WIDTH / 2);
  localparam logic [6:0] CENTRE_Y = 7'(HEIGHT / 2);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    GOAL  = 2'd2,
    OVER  = 2'd3
  } puck_state_e;

  // Zero-extend a 7-bit screen coordinate into signed headroom.
  function automatic logic signed [7:0] to_s8(input logic [6:0] v);
    return $signed({1'b0, v});
  endfunction

endpackage

// File: rtl/air_hockey_puck_collide.sv
// Combinational collision detector: wall bounce, paddle faces and goal lines
// for the puck's current position and direction of travel.
module puck_collide
  import air_hockey_pkg::*;
(
  input  logic [6:0] puck_x,
  input  logic [6:0] puck_y,
  input  logic       dx_neg,
  input  logic       dy_neg,
  input  logic [6:0] user_x,
  input  logic [6:0] user_y,
  input  logic [6:0] audio_x,
  input  logic [6:0] audio_y,
  output logic       wallFlipY,
  output logic       hitUser,
  output logic       hitAudio,
  output logic       goalLeft,
  output logic       goalRight
);

  localparam logic signed [7:0] HALF_S   = 8'(PUCK_HALF);
  localparam logic signed [7:0] SPEED_S  = 8'(SPEED);
  localparam logic signed [7:0] FACE_S   = 8'(PADDLE_W / 2);
  localparam logic signed [7:0] PAD_UP_S = 8'(PADDLE_H / 2);
  localparam logic signed [7:0] PAD_DN_S = 8'(PADDLE_H / 2 - 1);
  localparam logic signed [7:0] MAX_X_S  = 8'(WIDTH - 1);
  localparam logic signed [7:0] MAX_Y_S  = 8'(HEIGHT - 1);

  logic signed [7:0] px_s, py_s, ux_s, uy_s, ax_s, ay_s;
  logic              v_user_s, v_audio_s;

  assign px_s = to_s8(puck_x);
  assign py_s = to_s8(puck_y);
  assign ux_s = to_s8(user_x);
  assign uy_s = to_s8(user_y);
  assign ax_s = to_s8(audio_x);
  assign ay_s = to_s8(audio_y);

  // A hit needs the puck to reach the paddle face within this step while
  // still being in front of it, so a puck already past the face never bounces.
  always_comb begin
    v_user_s  = (py_s + HALF_S >= uy_s - PAD_UP_S) && (py_s - HALF_S <= uy_s + PAD_DN_S);
    v_audio_s = (py_s + HALF_S >= ay_s - PAD_UP_S) && (py_s - HALF_S <= ay_s + PAD_DN_S);
    wallFlipY = dy_neg ? (py_s - HALF_S - SPEED_S < 8'sd0)
                       : (py_s + HALF_S + SPEED_S > MAX_Y_S);
    hitUser   = dx_neg && (px_s - HALF_S > ux_s + FACE_S)
                       && (px_s - HALF_S - SPEED_S <= ux_s + FACE_S) && v_user_s;
    hitAudio  = !dx_neg && (px_s + HALF_S < ax_s - FACE_S)
                        && (px_s + HALF_S + SPEED_S >= ax_s - FACE_S) && v_audio_s;
    goalLeft  = dx_neg && !hitUser && (px_s < HALF_S + SPEED_S);
    goalRight = !dx_neg && !hitAudio && (px_s + HALF_S + SPEED_S > MAX_X_S);
  end

endmodule

// File: rtl/air_hockey_puck.sv
// Puck engine: serve/play/goal/over sequencing, puck motion, scoring and the
// per-pixel puck overlay for the OLED mux.
module air_hockey_puck
  import air_hockey_pkg::*;
(
  input  logic        clkPuck,
  input  logic        rst,
  input  logic        enable,
  input  logic        restart,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  input  logic [6:0]  userPaddleX,
  input  logic [6:0]  userPaddleY,
  input  logic [6:0]  audioPaddleX,
  input  logic [6:0]  audioPaddleY,
  output logic [6:0]  puckX,
  output logic [6:0]  puckY,
  output logic        puckAppear,
  output logic [15:0] puck_col,
  output logic [3:0]  userScore,
  output logic [3:0]  audioScore,
  output logic        goalPulse,
  output logic        gameOver,
  output logic        winner
);

  localparam logic [3:0]        SERVE_LAST = 4'(SERVE_TICKS - 1);
  localparam logic [3:0]        GOAL_LAST  = 4'(GOAL_TICKS - 1);
  localparam logic [3:0]        WIN        = 4'(WIN_SCORE);
  localparam logic [6:0]        STEP       = 7'(SPEED);
  localparam logic signed [7:0] HALF_S     = 8'(PUCK_HALF);

  puck_state_e state_q, state_d;
  logic [3:0]  timer_q, timer_d;
  logic [6:0]  px_q, px_d, py_q, py_d;
  logic        dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic        serve_dy_neg_q, serve_dy_neg_d;
  logic [3:0]  user_score_q, user_score_d, audio_score_q, audio_score_d;
  logic        goal_pulse_q, goal_pulse_d, winner_q, winner_d;

  logic wall_flip_y_s, hit_user_s, hit_audio_s, goal_left_s, goal_right_s;
  logic signed [7:0] rx_s, ry_s;

  puck_collide u_collide (
    .puck_x    (px_q),
    .puck_y    (py_q),
    .dx_neg    (dx_neg_q),
    .dy_neg    (dy_neg_q),
    .user_x    (userPaddleX),
    .user_y    (userPaddleY),
    .audio_x   (audioPaddleX),
    .audio_y   (audioPaddleY),
    .wallFlipY (wall_flip_y_s),
    .hitUser   (hit_user_s),
    .hitAudio  (hit_audio_s),
    .goalLeft  (goal_left_s),
    .goalRight (goal_right_s)
  );

  // State registers; rst returns everything to the opening serve.
  always_ff @(posedge clkPuck or posedge rst) begin
    if (rst) begin
      state_q        <= SERVE;
      timer_q        <= 4'd0;
      px_q           <= CENTRE_X;
      py_q           <= CENTRE_Y;
      dx_neg_q       <= 1'b1;
      dy_neg_q       <= 1'b0;
      serve_dy_neg_q <= 1'b0;
      user_score_q   <= 4'd0;
      audio_score_q  <= 4'd0;
      goal_pulse_q   <= 1'b0;
      winner_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      px_q           <= px_d;
      py_q           <= py_d;
      dx_neg_q       <= dx_neg_d;
      dy_neg_q       <= dy_neg_d;
      serve_dy_neg_q <= serve_dy_neg_d;
      user_score_q   <= user_score_d;
      audio_score_q  <= audio_score_d;
      goal_pulse_q   <= goal_pulse_d;
      winner_q       <= winner_d;
    end
  end

  // Next-state logic. dx is left untouched through GOAL, so it still points
  // at the side that conceded when the next serve starts.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    px_d           = px_q;
    py_d           = py_q;
    dx_neg_d       = dx_neg_q;
    dy_neg_d       = dy_neg_q;
    serve_dy_neg_d = serve_dy_neg_q;
    user_score_d   = user_score_q;
    audio_score_d  = audio_score_q;
    winner_d       = winner_q;
    goal_pulse_d   = 1'b0;
    if (enable) begin
      case (state_q)
        SERVE: begin
          if (timer_q == SERVE_LAST) begin
            timer_d = 4'd0;
            state_d = PLAY;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
        PLAY: begin
          if (wall_flip_y_s) begin
            dy_neg_d = !dy_neg_q;
          end else begin
            py_d = dy_neg_q ? (py_q - STEP) : (py_q + STEP);
          end
          if (hit_user_s) begin
            dx_neg_d = 1'b0;
          end else if (hit_audio_s) begin
            dx_neg_d = 1'b1;
          end else if (goal_left_s) begin
            audio_score_d = audio_score_q + 4'd1;
            goal_pulse_d  = 1'b1;
            timer_d       = 4'd0;
            state_d       = GOAL;
          end else if (goal_right_s) begin
            user_score_d = user_score_q + 4'd1;
            goal_pulse_d = 1'b1;
            timer_d      = 4'd0;
            state_d      = GOAL;
          end else begin
            px_d = dx_neg_q ? (px_q - STEP) : (px_q + STEP);
          end
        end
        GOAL: begin
          if (timer_q == GOAL_LAST) begin
            timer_d = 4'd0;
            if ((user_score_q == WIN) || (audio_score_q == WIN)) begin
              state_d  = OVER;
              winner_d = (audio_score_q == WIN);
            end else begin
              px_d           = CENTRE_X;
              py_d           = CENTRE_Y;
              dy_neg_d       = !serve_dy_neg_q;
              serve_dy_neg_d = !serve_dy_neg_q;
              state_d        = SERVE;
            end
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
        OVER: begin
          if (restart) begin
            user_score_d   = 4'd0;
            audio_score_d  = 4'd0;
            winner_d       = 1'b0;
            px_d           = CENTRE_X;
            py_d           = CENTRE_Y;
            dx_neg_d       = 1'b1;
            dy_neg_d       = 1'b0;
            serve_dy_neg_d = 1'b0;
            timer_d        = 4'd0;
            state_d        = SERVE;
          end else begin
            state_d = OVER;
          end
        end
        default: begin
          state_d = SERVE;
          timer_d = 4'd0;
        end
      endcase
    end else begin
      goal_pulse_d = 1'b0;
    end
  end

  assign rx_s = to_s8(x) - to_s8(px_q);
  assign ry_s = to_s8(y) - to_s8(py_q);

  // Pixel overlay: 3x3 square around the centre, hidden while a goal plays out.
  always_comb begin
    puckAppear = (rx_s >= -HALF_S) && (rx_s <= HALF_S) &&
                 (ry_s >= -HALF_S) && (ry_s <= HALF_S) && (state_q != GOAL);
  end

  assign puckX      = px_q;
  assign puckY      = py_q;
  assign puck_col   = COL_WHITE;
  assign userScore  = user_score_q;
  assign audioScore = audio_score_q;
  assign goalPulse  = goal_pulse_q;
  assign gameOver   = (state_q == OVER);
  assign winner     = winner_q;

endmodule

// File: tb/tb_air_hockey_puck.sv
// Bench for air_hockey_puck: integer game model checked every cycle, plus
// hand-computed trajectory points along a scripted match.
module tb_air_hockey_puck;

  logic        clk = 1'b0;
  logic        rst, enable, restart;
  logic [6:0]  x, y, ux, uy, ax, ay;
  logic [6:0]  puckX, puckY;
  logic        puckAppear, goalPulse, gameOver, winner;
  logic [15:0] puck_col;
  logic [3:0]  userScore, audioScore;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  bit scan_xy = 1'b1;
  int tick_no = 0;
  int dxo[6]  = '{0, 1, -1, 2, 0, -1};
  int dyo[6]  = '{0, 1, 0, 0, -2, -1};

  // game model
  int    m_x, m_y, m_vx, m_vy, m_serve_vy, m_us, m_as, m_cnt;
  string m_phase;
  bit    m_pulse, m_winner, m_conceded_left;

  air_hockey_puck dut (
    .clkPuck(clk), .rst(rst), .enable(enable), .restart(restart),
    .x(x), .y(y),
    .userPaddleX(ux), .userPaddleY(uy), .audioPaddleX(ax), .audioPaddleY(ay),
    .puckX(puckX), .puckY(puckY), .puckAppear(puckAppear), .puck_col(puck_col),
    .userScore(userScore), .audioScore(audioScore), .goalPulse(goalPulse),
    .gameOver(gameOver), .winner(winner)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 48; m_y = 32; m_vx = -1; m_vy = 1; m_serve_vy = 1;
    m_us = 0; m_as = 0; m_cnt = 0; m_phase = "serve";
    m_pulse = 1'b0; m_winner = 1'b0; m_conceded_left = 1'b1;
  endtask

  task automatic model_step();
    int  pux, puy, pax, pay;
    bit  hu, ha, gl, gr, wall;
    pux = int'(ux); puy = int'(uy); pax = int'(ax); pay = int'(ay);
    m_pulse = 1'b0;
    if (rst) begin
      model_reset();
    end else if (enable) begin
      if (m_phase == "serve") begin
        m_cnt++;
        if (m_cnt == 8) begin m_cnt = 0; m_phase = "play"; end
      end else if (m_phase == "play") begin
        hu = (m_vx < 0) && (m_x - 1 > pux + 1) && (m_x - 2 <= pux + 1) &&
             (m_y + 1 >= puy - 10) && (m_y - 1 <= puy + 9);
        ha = (m_vx > 0) && (m_x + 1 < pax - 1) && (m_x + 2 >= pax - 1) &&
             (m_y + 1 >= pay - 10) && (m_y - 1 <= pay + 9);
        gl = (m_vx < 0) && !hu && (m_x < 2);
        gr = (m_vx > 0) && !ha && (m_x + 2 > 95);
        wall = ((m_vy < 0) && (m_y - 2 < 0)) || ((m_vy > 0) && (m_y + 2 > 63));
        if (wall) m_vy = -m_vy; else m_y = m_y + m_vy;
        if (hu) m_vx = 1;
        else if (ha) m_vx = -1;
        else if (gl) begin m_as++; m_pulse = 1'b1; m_phase = "goal"; m_cnt = 0; m_conceded_left = 1'b1; end
        else if (gr) begin m_us++; m_pulse = 1'b1; m_phase = "goal"; m_cnt = 0; m_conceded_left = 1'b0; end
        else m_x = m_x + m_vx;
      end else if (m_phase == "goal") begin
        m_cnt++;
        if (m_cnt == 16) begin
          m_cnt = 0;
          if (m_us == 7 || m_as == 7) begin
            m_phase = "over"; m_winner = (m_as == 7);
          end else begin
            m_x = 48; m_y = 32;
            m_vx = m_conceded_left ? -1 : 1;
            m_serve_vy = -m_serve_vy; m_vy = m_serve_vy;
            m_phase = "serve";
          end
        end
      end else if (m_phase == "over" && restart) begin
        model_reset();
      end
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("cyc_puckX", puckX, m_x);
      check("cyc_puckY", puckY, m_y);
      check("cyc_userScore", userScore, m_us);
      check("cyc_audioScore", audioScore, m_as);
      check("cyc_goalPulse", goalPulse, m_pulse);
      check("cyc_gameOver", gameOver, m_phase == "over");
      if (m_phase == "over") check("cyc_winner", winner, m_winner);
      check("cyc_puckAppear", puckAppear,
            (int'(x) - m_x <= 1) && (m_x - int'(x) <= 1) &&
            (int'(y) - m_y <= 1) && (m_y - int'(y) <= 1) && (m_phase != "goal"));
      check("cyc_puck_col", puck_col, 16'hFFFF);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    tick_no++;
    if (scan_xy) begin
      x = 7'(m_x + dxo[tick_no % 6]);
      y = 7'(m_y + dyo[tick_no % 6]);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_until_goal(input int bound);
    int n = 0;
    do begin tick(); n++; end while (goalPulse !== 1'b1 && n < bound);
    check("goal_reached", goalPulse, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; restart = 1'b0; x = 7'd0; y = 7'd0;
    ux = 7'd3; uy = 7'd45; ax = 7'd90; ay = 7'd32;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_on = 1'b1;
    #1;
    check("rst_puckX", puckX, 48);
    check("rst_puckY", puckY, 32);
    check("rst_scores", {userScore, audioScore}, 0);
    check("rst_gameOver", gameOver, 0);
    check("rst_goalPulse", goalPulse, 0);
    check("rst_winner", winner, 0);

    enable = 1'b1;
    run(8);  check("serve_hold_x", puckX, 48);
    run(1);  check("first_move_x", puckX, 47); check("first_move_y", puckY, 33);
    run(10); restart = 1'b1; run(1); restart = 1'b0; run(17);
    check("bottom_y61", puckY, 61);
    run(1);  check("bottom_y62", puckY, 62);
    run(1);  check("bottom_hold62", puckY, 62);
    run(1);  check("bottom_back61", puckY, 61);
    run(10); check("hit_reach_x6", puckX, 6);
    run(1);  check("hit_hold_x6", puckX, 6);
    run(1);  check("hit_rebound_x7", puckX, 7); check("hit_rebound_y", puckY, 49);

    uy = 7'd50;
    enable = 1'b0;
    run(5);
    check("freeze_x", puckX, 7); check("freeze_y", puckY, 49);
    enable = 1'b1;

    run(162); check("miss_approach_x", puckX, 6); check("miss_approach_y", puckY, 11);
    for (int i = 5; i >= 1; i--) begin
      run(1); check("miss_pass_x", puckX, i);
    end
    check("pre_goal_score", audioScore, 0);
    run(1);
    check("goal_audioScore", audioScore, 1);
    check("goal_pulse_on", goalPulse, 1);
    check("goal_hold_x", puckX, 1);

    scan_xy = 1'b0; x = 7'd1; y = 7'd5;
    for (int i = 0; i < 16; i++) begin
      #1 check("goal_hidden", puckAppear, 0);
      tick();
      if (i == 0) check("goal_pulse_once", goalPulse, 0);
    end
    check("recentre_x", puckX, 48); check("recentre_y", puckY, 32);
    x = 7'd48; y = 7'd32;
    #1 check("recentre_visible", puckAppear, 1);
    scan_xy = 1'b1;
    run(9); check("serve2_x", puckX, 47); check("serve2_y", puckY, 31);

    ux = 7'd100;
    for (int g = 0; g < 6; g++) run_until_goal(200);
    check("win_audioScore", audioScore, 7);
    check("win_not_over_yet", gameOver, 0);
    run(16);
    check("over_gameOver", gameOver, 1);
    check("over_winner", winner, 1);
    check("over_userScore", userScore, 0);
    run(3);  check("over_frozen_x", puckX, 1); check("over_still", gameOver, 1);
    restart = 1'b1; run(1); restart = 1'b0;
    check("restart_scores", {userScore, audioScore}, 0);
    check("restart_gameOver", gameOver, 0);
    check("restart_winner", winner, 0);
    check("restart_x", puckX, 48); check("restart_y", puckY, 32);
    run(9); check("restart_serve_x", puckX, 47); check("restart_serve_y", puckY, 33);

    ux = 7'd3; uy = 7'd45; ax = 7'd0;
    run_until_goal(300);
    check("right_userScore", userScore, 1);
    check("right_audioScore", audioScore, 0);
    check("right_hold_x", puckX, 94);
    run(16); check("serve3_centre_x", puckX, 48);
    run(9);  check("serve3_x", puckX, 49); check("serve3_y", puckY, 31);

    ux = 7'd100;
    run_until_goal(300);
    run(5);
    #2 rst = 1'b1; model_reset();
    x = 7'd48; y = 7'd32;
    #1;
    check("async_x", puckX, 48); check("async_y", puckY, 32);
    check("async_scores", {userScore, audioScore}, 0);
    check("async_visible", puckAppear, 1);
    run(2);
    rst = 1'b0;
    run(9); check("post_rst_x", puckX, 47); check("post_rst_y", puckY, 33);

    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
